sha256_msg_schedule: RTL



---
 rtl/sha256_pkg.sv | 26 ++
 rtl/cla_add32.sv | 45 ++++
 rtl/sha256_sched_add4.sv | 38 +++
 rtl/sha256_msg_schedule.sv | 134 +++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, FSM state type and sigma functions for the SHA-256 message schedule.
package sha256_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned ROUNDS    = 64;
  localparam int unsigned T_W       = 6;
  localparam int unsigned WIN_DEPTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/cla_add32.sv
// 32-bit carry-look-ahead adder: 4-bit lookahead groups with group generate/propagate chaining.
module cla_add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_carry,
  output logic [31:0] o_sum,
  output logic        o_carry
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic [7:0]  bg;
  logic [7:0]  bp;
  logic [8:0]  bc;

  always_comb begin
    g  = i_a & i_b;
    p  = i_a ^ i_b;
    c  = '0;
    bg = '0;
    bp = '0;
    bc = '0;
    bc[0] = i_carry;
    for (int b = 0; b < 8; b++) begin
      bg[b] = g[4*b+3]
            | (p[4*b+3] & g[4*b+2])
            | (p[4*b+3] & p[4*b+2] & g[4*b+1])
            | (p[4*b+3] & p[4*b+2] & p[4*b+1] & g[4*b]);
      bp[b] = &p[4*b +: 4];
      c[4*b]   = bc[b];
      c[4*b+1] = g[4*b] | (p[4*b] & bc[b]);
      c[4*b+2] = g[4*b+1] | (p[4*b+1] & g[4*b])
               | (p[4*b+1] & p[4*b] & bc[b]);
      c[4*b+3] = g[4*b+2] | (p[4*b+2] & g[4*b+1])
               | (p[4*b+2] & p[4*b+1] & g[4*b])
               | (p[4*b+2] & p[4*b+1] & p[4*b] & bc[b]);
      bc[b+1]  = bg[b] | (bp[b] & bc[b]);
    end
    c[32]   = bc[8];
    o_sum   = p ^ c[31:0];
    o_carry = c[32];
  end

endmodule

// File: rtl/sha256_sched_add4.sv
// Four-operand mod-2^32 adder: three chained CLA adders, carries dropped.
module sha256_sched_add4 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  output logic [31:0] o_sum
);

  logic [31:0] sum_ab;
  logic [31:0] sum_abc;
  logic [2:0]  carry_unused;

  cla_add32 u_add_ab (
    .i_a     (i_a),
    .i_b     (i_b),
    .i_carry (1'b0),
    .o_sum   (sum_ab),
    .o_carry (carry_unused[0])
  );

  cla_add32 u_add_abc (
    .i_a     (sum_ab),
    .i_b     (i_c),
    .i_carry (1'b0),
    .o_sum   (sum_abc),
    .o_carry (carry_unused[1])
  );

  cla_add32 u_add_abcd (
    .i_a     (sum_abc),
    .i_b     (i_d),
    .i_carry (1'b0),
    .o_sum   (o_sum),
    .o_carry (carry_unused[2])
  );

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads a 512-bit block and streams W[0..63] over a valid/ready handshake.
// Optional i_abort input enabled by defining SHA256_SCHED_ABORT_EN.
module sha256_msg_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
`ifdef SHA256_SCHED_ABORT_EN
  input  logic                 i_abort,
`endif
  input  logic                 i_load_valid,
  output logic                 o_load_ready,
  input  logic [16*WORD_W-1:0] i_block,
  output logic                 o_w_valid,
  input  logic                 i_w_ready,
  output logic [WORD_W-1:0]    o_w,
  output logic [5:0]           o_t,
  output logic                 o_done
);

  import sha256_pkg::*;

  sched_state_e       state_q, state_d;
  logic [WORD_W-1:0]  win_q [WIN_DEPTH];
  logic [WORD_W-1:0]  win_d [WIN_DEPTH];
  logic [T_W-1:0]     t_q, t_d;
  logic               valid_q, valid_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;

  logic [WORD_W-1:0]  s0_c;
  logic [WORD_W-1:0]  s1_c;
  logic [WORD_W-1:0]  next_w_c;
  logic               load_c;
  logic               accept_c;
  logic               abort_c;

  assign s0_c = sigma0(win_q[1]);
  assign s1_c = sigma1(win_q[14]);

  // Next window tail: sigma1(W[t+14]) + W[t+9] + sigma0(W[t+1]) + W[t].
  sha256_sched_add4 u_add4 (
    .i_a   (s1_c),
    .i_b   (win_q[9]),
    .i_c   (s0_c),
    .i_d   (win_q[0]),
    .o_sum (next_w_c)
  );

`ifdef SHA256_SCHED_ABORT_EN
  assign abort_c = i_abort & (state_q == RUN);
`else
  assign abort_c = 1'b0;
`endif

  assign load_c   = i_load_valid & ready_q;
  assign accept_c = valid_q & i_w_ready;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
    valid_d = valid_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_c) begin
          for (int i = 0; i < WIN_DEPTH; i++) begin
            win_d[i] = i_block[(WIN_DEPTH-1-i)*WORD_W +: WORD_W];
          end
          t_d     = '0;
          state_d = RUN;
          valid_d = 1'b1;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        if (abort_c) begin
          t_d     = '0;
          state_d = IDLE;
          valid_d = 1'b0;
          ready_d = 1'b1;
        end else if (accept_c) begin
          for (int i = 0; i < WIN_DEPTH - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[WIN_DEPTH-1] = next_w_c;
          t_d = t_q + T_W'(1);
          // Last word taken: t wraps to 0 on its own.
          if (t_q == T_W'(ROUNDS - 1)) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_q[i] <= '0;
      end
      t_q     <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign o_load_ready = ready_q;
  assign o_w_valid    = valid_q;
  assign o_w          = win_q[0];
  assign o_t          = t_q;
  assign o_done       = done_q;

endmodule
